muldiv_unit: RTL

Multi-cycle multiply/divide unit in the execute stage, producing the `dest_hi_data`/`dest_lo_data` values carried in the execute→memory pipeline register. It accepts one HI/LO operation at a time and raises `busy` so the pipeline controller can stall the front of the pipe. `done` flags a finished result. Operand capture respects the controller's bubble/nullify semantics: a bubble blocks the start, and a nullify aborts the operation in flight.

---
 rtl/signals.sv | 38 +++
 rtl/muldiv_unit_serial_divider.sv | 36 +++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/signals.sv
// Shared types for the execute-stage HI/LO unit: operation codes, FSM states
// and the behavioural multiply/accumulate helper.
package signals;

  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE
  } muldiv_state_t;

  localparam int unsigned DIV_STEPS = 32;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  // Sign- or zero-extending to 64 bits makes one truncated multiply serve both flavours.
  function automatic logic [63:0] mul_result(input muldiv_op_t op, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [31:0] hi,
                                             input logic [31:0] lo);
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
    sgn = op inside {OP_MULT, OP_MADD, OP_MSUB};
    a   = {{32{sgn & rs[31]}}, rs};
    b   = {{32{sgn & rt[31]}}, rt};
    p   = a * b;
    case (op)
      OP_MADD, OP_MADDU: return {hi, lo} + p;
      OP_MSUB, OP_MSUBU: return {hi, lo} - p;
      default:           return p;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_serial_divider.sv
// Unsigned restoring divider core: one quotient bit per step, MSB first.
// After DIV_STEPS steps following a load, quotient/remainder are final.
module serial_divider (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [32:0] trial;
  logic        fits;

  assign trial     = {rem_q, quo_q[31]};
  assign fits      = trial >= {1'b0, dvs_q};
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // NOTE: pure datapath registers are left unreset; load always initialises them before use.
  always_ff @(posedge clk) begin
    if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
      quo_q <= {quo_q[30:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit with bubble/nullify-aware start and
// registered busy/done/result outputs.
module muldiv_unit
  import signals::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        bubble,
  input  logic        nullify,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  muldiv_state_t state, state_nxt;
  logic          accept;
  logic          load;
  logic          step;
  logic          mul_last;
  logic          div_last;
  muldiv_op_t    op_q;
  logic [31:0]   rs_q;
  logic [31:0]   rt_q;
  logic [MCW-1:0] mul_cnt;
  logic [4:0]    div_cnt;
  logic [63:0]   mul_pipe [MUL_LAT];
  logic [31:0]   abs_rs;
  logic [31:0]   abs_rt;
  logic [31:0]   quotient;
  logic [31:0]   remainder;
  logic [31:0]   fix_hi;
  logic [31:0]   fix_lo;

  assign abs_rs   = (op == OP_DIV && rs[31]) ? -rs : rs;
  assign abs_rt   = (op == OP_DIV && rt[31]) ? -rt : rt;
  assign mul_last = mul_cnt == MCW'(MUL_LAT - 1);
  assign div_last = div_cnt == 5'(DIV_STEPS - 1);
  assign load     = accept & is_div(op);
  assign busy     = state inside {ST_MUL, ST_DIV, ST_FIX};
  assign done     = state == ST_DONE;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (start && !bubble && !nullify) begin
          accept    = 1'b1;
          state_nxt = is_div(op) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (nullify)       state_nxt = ST_IDLE;
        else if (mul_last) state_nxt = ST_DONE;
      end
      ST_DIV: begin
        step = 1'b1;
        if (nullify)       state_nxt = ST_IDLE;
        else if (div_last) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = nullify ? ST_IDLE : ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state_nxt == ST_DONE && state != ST_DONE) begin
      if (state == ST_MUL) {hi_out, lo_out} <= mul_pipe[MUL_LAT-1];
      else                 {hi_out, lo_out} <= {fix_hi, fix_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q        <= op;
      rs_q        <= rs;
      rt_q        <= rt;
      mul_cnt     <= '0;
      div_cnt     <= '0;
      mul_pipe[0] <= mul_result(op, rs, rt, hi_in, lo_in);
    end else begin
      mul_cnt <= mul_cnt + 1'b1;
      div_cnt <= div_cnt + 1'b1;
    end
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  // Sign restoration plus the divide-by-zero and 0x80000000/-1 special cases.
  always_comb begin
    fix_hi = remainder;
    fix_lo = quotient;
    if (rt_q == '0) begin
      fix_lo = '1;
      fix_hi = rs_q;
    end else if (op_q == OP_DIV) begin
      if (rs_q == 32'h8000_0000 && rt_q == '1) begin
        fix_lo = 32'h8000_0000;
        fix_hi = '0;
      end else begin
        if (rs_q[31] ^ rt_q[31]) fix_lo = -quotient;
        if (rs_q[31])            fix_hi = -remainder;
      end
    end
  end

  serial_divider u_div (
    .clk      (clk),
    .load     (load),
    .step     (step),
    .dividend (abs_rs),
    .divisor  (abs_rt),
    .quotient (quotient),
    .remainder(remainder)
  );

endmodule
